// File: rtl/chacha_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chacha_pkg
// Brief    : Shared constants, FSM state type and quarter-round index helper
//            for the ChaCha20 block core.
// Revision : 1.0 - initial release
// ============================================================================
package chacha_pkg;

    // State-word width and total number of half-rounds (10 double rounds)
    localparam int c_word_w = 32;
    localparam int c_rounds = 20;

    // "expand 32-byte k" constant words 0..3
    localparam logic [31:0] c_sigma0 = 32'h6170_7865;
    localparam logic [31:0] c_sigma1 = 32'h3320_646e;
    localparam logic [31:0] c_sigma2 = 32'h7962_2d32;
    localparam logic [31:0] c_sigma3 = 32'h6b20_6574;

    // Block-core control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Word index for lane q, row r of the 4x4 state matrix. Columns keep the
    // lane's column on every row; diagonals shift the column right by the row
    // number, wrapping modulo 4.
    function automatic logic [3:0] qr_index(input logic [1:0] q,
                                            input logic [1:0] row,
                                            input logic       diag);
        logic [1:0] col;
        col = diag ? (q + row) : q;
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/chacha_quarterround.sv
`default_nettype none
// ============================================================================
// Module   : chacha_quarterround
// Brief    : Combinational ChaCha quarter round (add / xor / rotate 16,12,8,7).
// Revision : 1.0 - initial release
// ============================================================================
module chacha_quarterround
    import chacha_pkg::*;
(
    input  logic [c_word_w-1:0] i_a,
    input  logic [c_word_w-1:0] i_b,
    input  logic [c_word_w-1:0] i_c,
    input  logic [c_word_w-1:0] i_d,
    output logic [c_word_w-1:0] o_a,
    output logic [c_word_w-1:0] o_b,
    output logic [c_word_w-1:0] o_c,
    output logic [c_word_w-1:0] o_d
);

    // Each intermediate step gets its own wire so every value has one driver
    logic [c_word_w-1:0] w_a1, w_d1x, w_d1, w_c1, w_b1x, w_b1;
    logic [c_word_w-1:0] w_a2, w_d2x, w_d2, w_c2, w_b2x, w_b2;

    assign w_a1  = i_a + i_b;
    assign w_d1x = i_d ^ w_a1;
    assign w_d1  = {w_d1x[15:0], w_d1x[31:16]};
    assign w_c1  = i_c + w_d1;
    assign w_b1x = i_b ^ w_c1;
    assign w_b1  = {w_b1x[19:0], w_b1x[31:20]};
    assign w_a2  = w_a1 + w_b1;
    assign w_d2x = w_d1 ^ w_a2;
    assign w_d2  = {w_d2x[23:0], w_d2x[31:24]};
    assign w_c2  = w_c1 + w_d2;
    assign w_b2x = w_b1 ^ w_c2;
    assign w_b2  = {w_b2x[24:0], w_b2x[31:25]};

    assign o_a = w_a2;
    assign o_b = w_b2;
    assign o_c = w_c2;
    assign o_d = w_d2;

endmodule
`default_nettype wire

// File: rtl/chacha_block_core.sv
`default_nettype none
// ============================================================================
// Module   : chacha_block_core
// Brief    : Iterative ChaCha20 block function, one half-round per cycle,
//            valid/ready keystream output.
// Revision : 1.0 - initial release
// ============================================================================
module chacha_block_core
    import chacha_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    state_t              r_state;
    logic [4:0]          r_round_cnt;
    logic [c_word_w-1:0] r_work  [16];
    logic [c_word_w-1:0] r_saved [16];
    logic [511:0]        r_keystream;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_ks_valid;

    logic [c_word_w-1:0] w_init      [16];
    logic [c_word_w-1:0] w_next_work [16];
    logic [c_word_w-1:0] w_qa [4];
    logic [c_word_w-1:0] w_qb [4];
    logic [c_word_w-1:0] w_qc [4];
    logic [c_word_w-1:0] w_qd [4];
    logic [c_word_w-1:0] w_ra [4];
    logic [c_word_w-1:0] w_rb [4];
    logic [c_word_w-1:0] w_rc [4];
    logic [c_word_w-1:0] w_rd [4];
    logic                w_diag;

    assign w_diag = r_round_cnt[0];

    // Initial state matrix: constants, key, block counter, nonce
    always_comb begin
        w_init[0] = c_sigma0;
        w_init[1] = c_sigma1;
        w_init[2] = c_sigma2;
        w_init[3] = c_sigma3;
        for (int i = 0; i < 8; i++) begin
            w_init[4 + i] = key[32*i +: 32];
        end
        w_init[12] = counter;
        for (int j = 0; j < 3; j++) begin
            w_init[13 + j] = nonce[32*j +: 32];
        end
    end

    // Route column or diagonal quads into the four quarter-round lanes and
    // scatter the results back to the same word positions
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_next_work[i] = r_work[i];
        end
        for (int q = 0; q < 4; q++) begin
            w_qa[q] = r_work[qr_index(2'(q), 2'd0, w_diag)];
            w_qb[q] = r_work[qr_index(2'(q), 2'd1, w_diag)];
            w_qc[q] = r_work[qr_index(2'(q), 2'd2, w_diag)];
            w_qd[q] = r_work[qr_index(2'(q), 2'd3, w_diag)];
            w_next_work[qr_index(2'(q), 2'd0, w_diag)] = w_ra[q];
            w_next_work[qr_index(2'(q), 2'd1, w_diag)] = w_rb[q];
            w_next_work[qr_index(2'(q), 2'd2, w_diag)] = w_rc[q];
            w_next_work[qr_index(2'(q), 2'd3, w_diag)] = w_rd[q];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_qr
            chacha_quarterround u_qr (
                .i_a (w_qa[gi]),
                .i_b (w_qb[gi]),
                .i_c (w_qc[gi]),
                .i_d (w_qd[gi]),
                .o_a (w_ra[gi]),
                .o_b (w_rb[gi]),
                .o_c (w_rc[gi]),
                .o_d (w_rd[gi])
            );
        end
    endgenerate

    // Control FSM with registered status outputs and the state/keystream regs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_round_cnt <= '0;
            r_keystream <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_ks_valid  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_work[i]  <= '0;
                r_saved[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            r_work[i]  <= w_init[i];
                            r_saved[i] <= w_init[i];
                        end
                        r_round_cnt <= '0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    for (int i = 0; i < 16; i++) begin
                        r_work[i] <= w_next_work[i];
                    end
                    r_round_cnt <= r_round_cnt + 5'd1;
                    if (r_round_cnt == 5'(c_rounds - 1)) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 16; i++) begin
                        r_keystream[32*i +: 32] <= r_work[i] + r_saved[i];
                    end
                    r_busy     <= 1'b0;
                    r_ks_valid <= 1'b1;
                    r_state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (ks_ready) begin
                        r_ks_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign ks_valid  = r_ks_valid;
    assign keystream = r_keystream;

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_block_core
// Brief    : Self-checking bench for chacha_block_core against an RFC-style
//            ChaCha20 reference and a cycle-count handshake model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         in_ready;
    logic [255:0] key;
    logic [31:0]  counter;
    logic [95:0]  nonce;
    logic         ks_valid;
    logic         ks_ready;
    logic [511:0] keystream;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    chacha_block_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .key       (key),
        .counter   (counter),
        .nonce     (nonce),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .keystream (keystream),
        .busy      (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Reference ChaCha20 block: 10 double rounds then feed-forward add
    function automatic logic [511:0] chacha_ref(input logic [255:0] k,
                                                input logic [31:0]  c,
                                                input logic [95:0]  n);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
        for (int i = 0; i < 16; i++) x[i] = s[i];
        for (int dr = 0; dr < 10; dr++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = computing (21 edges), 2 = holding output
    int           m_mode  = 0;
    int           m_cnt   = 0;
    logic [511:0] m_pending = '0;
    logic [511:0] m_ks      = '0;
    bit           m_armed   = 1'b0;

    // Advance the model on every rising edge from the sampled inputs
    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_ks    = '0;
            m_armed = 1'b1;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_pending = chacha_ref(key, counter, nonce);
                    m_cnt     = 21;
                    m_mode    = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_ks   = m_pending;
                        m_mode = 2;
                    end
                end
                default: if (ks_ready) m_mode = 0;
            endcase
        end
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        if (m_armed) begin
            chk("cyc_in_ready",  512'(in_ready), 512'(m_mode == 0));
            chk("cyc_busy",      512'(busy),     512'(m_mode == 1));
            chk("cyc_ks_valid",  512'(ks_valid), 512'(m_mode == 2));
            chk("cyc_keystream", keystream,      m_ks);
        end
    end

    // Start a block and measure the cycles until ks_valid (bounded)
    task automatic run_block(input logic [255:0] k, input logic [31:0] c,
                             input logic [95:0] n, output logic [511:0] exp);
        int cyc;
        key = k; counter = c; nonce = n; start = 1'b1;
        exp = chacha_ref(k, c, n);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!ks_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 512'(cyc), 512'(21));
    endtask

    task automatic consume();
        ks_ready = 1'b1;
        @(negedge clk);
        ks_ready = 1'b0;
    endtask

    logic [255:0] k_vec;
    logic [511:0] exp_ks;
    logic [511:0] pin;
    int           pulses;

    // Directed and randomized stimulus
    initial begin
        rst_n = 1'b0; start = 1'b0; ks_ready = 1'b0;
        key = '0; counter = '0; nonce = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  512'(in_ready), 512'(1));
        chk("rst_ks_valid",  512'(ks_valid), 512'(0));
        chk("rst_busy",      512'(busy),     512'(0));
        chk("rst_keystream", keystream,      '0);
        rst_n = 1'b1;

        // Pin the reference model against published vectors
        for (int b = 0; b < 32; b++) k_vec[8*b +: 8] = 8'(b);
        pin = chacha_ref(k_vec, 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000});
        chk("model_rfc_w0", 512'(pin[31:0]),   512'(32'he4e7f110));
        chk("model_rfc_w3", 512'(pin[127:96]), 512'(32'hc47120a3));
        pin = chacha_ref('0, 32'd0, '0);
        chk("model_zero_w0", 512'(pin[31:0]),  512'(32'hade0b876));
        chk("model_zero_w1", 512'(pin[63:32]), 512'(32'h903df1a0));

        // Known-answer block
        @(negedge clk);
        run_block(k_vec, 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000}, exp_ks);
        chk("kat_w0", 512'(keystream[31:0]),   512'(32'he4e7f110));
        chk("kat_w1", 512'(keystream[63:32]),  512'(32'h15593bd1));
        chk("kat_w2", 512'(keystream[95:64]),  512'(32'h1fdd0f50));
        chk("kat_w3", 512'(keystream[127:96]), 512'(32'hc47120a3));

        // Back-pressure with a stray start pulse
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(negedge clk);
            chk("hold_keystream", keystream, exp_ks);
            chk("hold_in_ready",  512'(in_ready), 512'(0));
            chk("hold_ks_valid",  512'(ks_valid), 512'(1));
        end
        start = 1'b0;
        consume();
        chk("hs_ks_valid", 512'(ks_valid), 512'(0));
        chk("hs_in_ready", 512'(in_ready), 512'(1));

        // New block accepted right after the handshake; wrap-around counter
        run_block('0, 32'hFFFFFFFF, '0, exp_ks);
        chk("wrap_keystream", keystream, exp_ks);
        chk("wrap_ctr_kept", keystream, chacha_ref('0, 32'hFFFFFFFF, '0));
        consume();

        // Abort mid-computation when round_cnt reaches 7
        key = k_vec; counter = 32'd5; nonce = 96'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready",  512'(in_ready), 512'(1));
        chk("abort_busy",      512'(busy),     512'(0));
        chk("abort_keystream", keystream,      '0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ks_valid) pulses++;
        end
        chk("abort_no_valid", 512'(pulses), 512'(0));

        // Randomized traffic: random operands, start and ks_ready every cycle
        for (int i = 0; i < 600; i++) begin
            for (int w = 0; w < 8; w++) key[32*w +: 32] = $urandom;
            counter = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            nonce   = {$urandom, $urandom, $urandom};
            start    = ($urandom_range(0, 3) == 0);
            ks_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0; ks_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chacha_block_core.md
CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset named rst_n.
REQ-002 Port: clk, input, 1, rising-edge clock for all state.
REQ-003 Port: rst_n, input, 1, synchronous active-low reset.
REQ-004 Port: start, input, 1, request to compute one 64-byte block; qualified by in_ready.
REQ-005 Port: in_ready, output, 1, high only in IDLE.
REQ-006 Port: key, input, 256, key; state word 4+i = key[32i+31:32i], i=0..7.
REQ-007 Port: counter, input, 32, block counter; becomes state word 12.
REQ-008 Port: nonce, input, 96, nonce; state word 13+j = nonce[32j+31:32j], j=0..2.
REQ-009 Port: ks_valid, output, 1, keystream block available.
REQ-010 Port: ks_ready, input, 1, consumer accepts the keystream block.
REQ-011 Port: keystream, output, 512, result; word i = keystream[32i+31:32i], i=0..15.
REQ-012 Port: busy, output, 1, high in ROUND or FINAL.

Function
REQ-013 State words 0..3 SHALL be 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
REQ-014 The FSM SHALL have four states: IDLE, ROUND, FINAL and OUT.
REQ-015 Accept: on a clock edge with start=1 in IDLE, load the initial state into both the working and saved registers, set round_cnt=0 and go to ROUND.
REQ-016 start in any state other than IDLE SHALL be ignored, with no effect on the state or outputs.
REQ-017 ROUND: each cycle performs one half-round with four parallel quarter rounds.
REQ-018 Even round_cnt SHALL use columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
REQ-019 Odd round_cnt SHALL use diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-020 round_cnt SHALL increment each ROUND cycle; after the edge where round_cnt=19, go to FINAL.
REQ-021 FINAL: for one cycle, register keystream word i = working[i] + saved[i] mod 2^32, then go to OUT.
REQ-022 All additions SHALL be 32-bit modulo 2^32 with no carry between words.
REQ-023 counter=0xFFFFFFFF SHALL be used as-is; the block never increments counter.
REQ-024 Latency: ks_valid SHALL rise exactly 21 cycles after the accept edge (20 ROUND + 1 FINAL).
REQ-025 OUT: ks_valid=1; keystream SHALL be held stable until an edge with ks_ready=1, then go to IDLE with ks_valid=0.
REQ-026 ks_ready SHALL be ignored outside OUT.
REQ-027 An edge with ks_valid and ks_ready both high SHALL take the block to IDLE.
REQ-028 in_ready SHALL be 1 on the cycle after that handshake edge; no same-cycle start/handshake overlap.
REQ-029 keystream SHALL change only on the FINAL edge and on reset.

Reset
REQ-030 rst_n=0 at an edge SHALL force IDLE, round_cnt=0, ks_valid=0, busy=0, keystream=0 and all working/saved words=0.
REQ-031 After reset, in_ready SHALL be 1.
REQ-032 Reset asserted during ROUND, FINAL or OUT SHALL abort the block and discard all partial state.
REQ-033 No keystream SHALL be emitted for a block aborted by reset.

Structure
REQ-034 A shared package chacha_pkg SHALL hold the four constant words, the round count (20), the state-word width (32) and the FSM state enum.
REQ-035 The core SHALL instantiate sub-module chacha_quarterround four times: add, xor, rotl 16/12/8/7, with each intermediate value driven once.
REQ-036 The quarter-round outputs SHALL feed the working-state register through a column/diagonal index mux selected by round_cnt[0].

Verification
REQ-037 Reset check: hold rst_n=0 for 2 cycles -> in_ready=1, ks_valid=0, keystream=0, busy=0.
REQ-038 Block vector: key bytes 00..1f (word4=0x03020100), counter=1, nonce words 0x09000000/0x4a000000/0x00000000 -> after 21 cycles keystream words 0..3 = e4e7f110, 15593bd1, 1fdd0f50, c47120a3.
REQ-039 Back-pressure: hold ks_ready=0 for 10 cycles in OUT, and pulse start during OUT -> keystream stable, start ignored, in_ready=0.
REQ-040 Handshake: raise ks_ready -> ks_valid=0 next cycle and in_ready=1; a new start is then accepted.
REQ-041 Abort: assert rst_n=0 at round_cnt=7 -> IDLE and zeros next cycle, no ks_valid pulse.
REQ-042 Wrap: key=0, nonce=0, counter=0xFFFFFFFF -> output matches the golden model with mod-2^32 sums and counter not incremented.
